// File: rtl/deser_arb_pkg.sv
// Shared types and helpers for deser_arbiter: FSM state, round-robin pick, word/beat ratio.
package deser_arb_pkg;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic int calc_no_cyc(input int bw_out, input int bw_in);
    return bw_out / bw_in;
  endfunction

  // First set bit of vld[n-1:0] searching upward from start with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                    input int unsigned start,
                                    input int unsigned n);
    pick_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = start + i;
      if (j >= n) j = j - n;
      if (i < n && !res.found && vld[j[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over vld, searching upward from start with wrap.
module rr_arbiter
  import deser_arb_pkg::*;
#(
  parameter int NO_REQ = 4,
  parameter int ID_W   = $clog2(NO_REQ)
) (
  input  logic [NO_REQ-1:0] vld,
  input  logic [ID_W-1:0]   start,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(vld), 32'(start), NO_REQ);
    found = pick.found;
    idx   = ID_W'(pick.idx);
  end

endmodule

// File: rtl/deser_arbiter.sv
// Round-robin arbiter granting whole BW_OUT words of a shared from_serial deserializer.
// Optional DESER_CHECK_EN: sticky sync_err when deser_vld disagrees with tag_vld.
module deser_arbiter
  import deser_arb_pkg::*;
#(
  parameter int NO_REQ = 4,
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 2,
  parameter int BW_OUT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NO_REQ-1:0]                       req_vld,
  input  logic [NO_REQ-1:0][NO_CH-1:0][BW_IN-1:0] req_data,
  output logic [NO_REQ-1:0]                       req_rdy,
  output logic                                    ser_vld,
  output logic [NO_CH-1:0][BW_IN-1:0]             ser_data,
  input  logic                                    deser_vld,
  output logic                                    tag_vld,
  output logic [$clog2(NO_REQ)-1:0]               tag_id,
  output logic                                    sync_err
);

  localparam int NO_CYC = calc_no_cyc(BW_OUT, BW_IN);
  localparam int CNT_W  = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
  localparam int ID_W   = $clog2(NO_REQ);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NO_CYC - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NO_REQ - 1);

  generate
    if (BW_OUT % BW_IN != 0) begin : g_bad_ratio
      $fatal(1, "deser_arbiter: BW_OUT must be an integer multiple of BW_IN");
    end
    if (NO_REQ < 2 || NO_REQ > MAX_REQ) begin : g_bad_req
      $fatal(1, "deser_arbiter: NO_REQ out of range");
    end
  endgenerate

  state_t            state_reg;
  logic [ID_W-1:0]   owner_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              tag_vld_reg;
  logic [ID_W-1:0]   tag_id_reg;

  logic [ID_W-1:0]   owner_inc;
  logic [ID_W-1:0]   arb_start;
  logic              arb_found;
  logic [ID_W-1:0]   arb_idx;
  logic              beat_accept;
  logic              last_beat;

  // One arbiter serves both IDLE and last-beat paths; rr_ptr equals owner+1 after a word.
  assign owner_inc = (owner_reg == LAST_ID) ? '0 : owner_reg + ID_W'(1);
  assign arb_start = (state_reg == BURST) ? owner_inc : rr_ptr_reg;

  rr_arbiter #(.NO_REQ(NO_REQ), .ID_W(ID_W)) u_rr (
    .vld   (req_vld),
    .start (arb_start),
    .found (arb_found),
    .idx   (arb_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NO_REQ; gi++) begin : g_rdy
      assign req_rdy[gi] = (state_reg == BURST) && (owner_reg == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    ser_vld  = 1'b0;
    ser_data = '0;
    if (state_reg == BURST) begin
      ser_vld  = req_vld[owner_reg];
      ser_data = req_data[owner_reg];
    end
  end

  assign beat_accept = (state_reg == BURST) && req_vld[owner_reg];
  assign last_beat   = beat_accept && (beat_cnt_reg == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      tag_vld_reg  <= 1'b0;
      tag_id_reg   <= '0;
    end else begin
      tag_vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            owner_reg    <= arb_idx;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (last_beat) begin
            rr_ptr_reg   <= owner_inc;
            beat_cnt_reg <= '0;
            tag_vld_reg  <= 1'b1;
            tag_id_reg   <= owner_reg;
            if (arb_found) owner_reg <= arb_idx;
            else           state_reg <= IDLE;
          end else if (beat_accept) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tag_vld = tag_vld_reg;
  assign tag_id  = tag_id_reg;

`ifdef DESER_CHECK_EN
  logic sync_err_reg;
  always_ff @(posedge clk) begin
    if (rst)                           sync_err_reg <= 1'b0;
    else if (deser_vld != tag_vld_reg) sync_err_reg <= 1'b1;
  end
  assign sync_err = sync_err_reg;
`else
  logic unused_deser_vld;
  assign unused_deser_vld = deser_vld;
  assign sync_err         = 1'b0;
`endif

endmodule

// File: tb/tb_deser_arbiter.sv
// Self-checking bench for deser_arbiter with a behavioural deserializer and arbiter model.
module tb_deser_arbiter;

  localparam int NO_REQ = 4;
  localparam int NO_CH  = 10;
  localparam int BW_IN  = 2;
  localparam int BW_OUT = 8;
  localparam int NO_CYC = BW_OUT / BW_IN;
`ifdef DESER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [NO_CH-1:0][BW_OUT-1:0] word_t;
  typedef logic [NO_CH-1:0][BW_IN-1:0]  beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NO_REQ-1:0]        req_vld = '0;
  logic [NO_REQ-1:0][NO_CH-1:0][BW_IN-1:0] req_data = '0;
  logic [NO_REQ-1:0]        req_rdy;
  logic                     ser_vld;
  beat_t                    ser_data;
  logic                     deser_vld;
  logic                     tag_vld;
  logic [1:0]               tag_id;
  logic                     sync_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  deser_arbiter #(.NO_REQ(NO_REQ), .NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .ser_vld(ser_vld), .ser_data(ser_data), .deser_vld(deser_vld),
    .tag_vld(tag_vld), .tag_id(tag_id), .sync_err(sync_err)
  );

  function automatic word_t put_beat(word_t w, int k, beat_t b);
    for (int ch = 0; ch < NO_CH; ch++) w[ch][k*BW_IN +: BW_IN] = b[ch];
    return w;
  endfunction

  // Stand-in for the from_serial deserializer: LSB-first beats, vld_out one cycle after word end.
  word_t d_acc, d_out;
  int    d_cnt;
  logic  d_vld;
  logic  force_dv = 1'b0;
  assign deser_vld = d_vld | force_dv;

  always @(posedge clk) begin
    if (rst) begin
      d_cnt <= 0;
      d_vld <= 1'b0;
    end else begin
      d_vld <= 1'b0;
      if (ser_vld) begin
        d_acc <= put_beat(d_acc, d_cnt, ser_data);
        if (d_cnt == NO_CYC - 1) begin
          d_out <= put_beat(d_acc, d_cnt, ser_data);
          d_vld <= 1'b1;
          d_cnt <= 0;
        end else begin
          d_cnt <= d_cnt + 1;
        end
      end
    end
  end

  // Reference model of the arbiter's observable behaviour.
  bit    m_busy = 0;
  int    m_owner = 0, m_cnt = 0, m_ptr = 0, m_tag_id = 0;
  bit    m_tag_vld = 0, m_sync_err = 0;
  word_t m_word = '0, m_done_word = '0;
  int    tags_q[$];

  function automatic int pick_from(logic [NO_REQ-1:0] v, int start);
    for (int k = 0; k < NO_REQ; k++)
      if (v[(start + k) % NO_REQ]) return (start + k) % NO_REQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NO_REQ-1:0] exp_rdy, v;
    logic              exp_sv, r, dv_s;
    beat_t             exp_sd;
    logic [NO_REQ-1:0][NO_CH-1:0][BW_IN-1:0] d;
    int p;
    #1;
    v = req_vld; d = req_data; r = rst; dv_s = deser_vld;
    exp_rdy = '0;
    if (m_busy) exp_rdy[m_owner] = 1'b1;
    exp_sv = m_busy && v[m_owner];
    exp_sd = m_busy ? d[m_owner] : '0;
    chk("req_rdy", 80'(req_rdy), 80'(exp_rdy));
    chk("ser_vld", 80'(ser_vld), 80'(exp_sv));
    chk("ser_data", 80'(ser_data), 80'(exp_sd));
    chk("tag_vld", 80'(tag_vld), 80'(m_tag_vld));
    chk("sync_err", 80'(sync_err), 80'(m_sync_err));
    if (m_tag_vld) begin
      chk("tag_id", 80'(tag_id), 80'(m_tag_id));
      chk("deser_word", 80'(d_out), 80'(m_done_word));
    end
    if (tag_vld === 1'b1) tags_q.push_back(int'(tag_id));
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      m_tag_vld = 0; m_tag_id = 0; m_sync_err = 0;
    end else begin
      if (CHK && (dv_s != m_tag_vld)) m_sync_err = 1;
      m_tag_vld = 0;
      if (!m_busy) begin
        p = pick_from(v, m_ptr);
        if (p >= 0) begin m_busy = 1; m_owner = p; m_cnt = 0; end
      end else if (v[m_owner]) begin
        m_word = put_beat(m_word, m_cnt, d[m_owner]);
        if (m_cnt == NO_CYC - 1) begin
          m_done_word = m_word;
          m_tag_vld = 1; m_tag_id = m_owner;
          m_ptr = (m_owner + 1) % NO_REQ;
          m_cnt = 0;
          p = pick_from(v, m_ptr);
          if (p >= 0) m_owner = p; else m_busy = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_all(input int rq, input logic [1:0] val);
    for (int ch = 0; ch < NO_CH; ch++) req_data[rq][ch] = val;
  endtask

  task automatic rand_data();
    for (int rq = 0; rq < NO_REQ; rq++)
      for (int ch = 0; ch < NO_CH; ch++) req_data[rq][ch] = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  logic [1:0] bt_a[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] bt_b[4] = '{2'd3, 2'd0, 2'd1, 2'd2};
  word_t w39, w93;

  initial begin
    for (int ch = 0; ch < NO_CH; ch++) begin w39[ch] = 8'h39; w93[ch] = 8'h93; end
    repeat (2) @(negedge clk);
    do_reset();
    chk("reset_tag_id", 80'(tag_id), 80'(0));

    // Single requester, beats 1,2,3,0.
    req_vld = 4'b0100;
    for (int k = 0; k < 5; k++) begin set_all(2, bt_a[m_cnt]); step(); end
    req_vld = 4'b0000;
    tags_q.delete();
    step();
    chk("single_tags", 80'(tags_q.size()), 80'(1));
    chk("single_word", 80'(d_out), 80'(w39));

    // All four continuously valid.
    do_reset(); tags_q.delete();
    req_vld = 4'b1111;
    for (int k = 0; k < 18; k++) begin rand_data(); step(); end
    chk("rr_tag_count", 80'(tags_q.size()), 80'(4));
    for (int k = 0; k < 4 && k < tags_q.size(); k++)
      chk("rr_tag_order", 80'(tags_q[k]), 80'(k));

    // Owner 1 stalls mid-word while requester 3 waits.
    do_reset(); req_vld = 4'b0010;
    for (int k = 0; k < 3; k++) begin rand_data(); step(); end
    req_vld = 4'b1000;
    for (int k = 0; k < 5; k++) begin #1 chk("stall_rdy", 80'(req_rdy), 80'(4'b0010)); step(); end
    req_vld = 4'b1010;
    for (int k = 0; k < 2; k++) begin rand_data(); step(); end
    #1 chk("no_bubble_rdy", 80'(req_rdy), 80'(4'b1000));
    chk("stall_tag_vld", 80'(tag_vld), 80'(1));
    chk("stall_tag_id", 80'(tag_id), 80'(1));
    step();

    // Reset after two beats of requester 0; then a fresh word.
    do_reset(); req_vld = 4'b0001;
    for (int k = 0; k < 3; k++) begin set_all(0, bt_b[m_cnt]); step(); end
    rst = 1'b1; step(); rst = 1'b0;
    #1 chk("post_rst_rdy", 80'(req_rdy), 80'(0));
    tags_q.delete();
    for (int k = 0; k < 5; k++) begin set_all(0, bt_b[m_cnt]); step(); end
    req_vld = 4'b0000;
    step();
    chk("fresh_tags", 80'(tags_q.size()), 80'(1));
    if (tags_q.size() > 0) chk("fresh_tag_id", 80'(tags_q[0]), 80'(0));
    chk("fresh_word", 80'(d_out), 80'(w93));

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_vld = 4'($urandom_range(0, 15));
      rand_data();
      step();
    end

    // Spurious deser_vld with no pending tag.
    req_vld = 4'b0000;
    do_reset();
    repeat (6) step();
    force_dv = 1'b1; step(); force_dv = 1'b0;
    #1 chk("sync_err_set", 80'(sync_err), 80'(CHK));
    for (int k = 0; k < 30; k++) begin
      req_vld = 4'($urandom_range(0, 15));
      rand_data();
      step();
    end
    #1 chk("sync_err_sticky", 80'(sync_err), 80'(CHK));
    req_vld = 4'b0000;
    do_reset();
    #1 chk("sync_err_clear", 80'(sync_err), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/deser_arbiter.md
Name: deser_arbiter

Overview:
- Round-robin arbiter that shares one multi-channel from_serial deserializer between NO_REQ narrow-beat requesters.
- Grants whole words only: a grant is held for exactly NO_CYC accepted beats, so beats from different requesters never mix inside one BW_OUT word.
- Drives the deserializer's vld_in/data_in and emits an owner tag aligned with the deserializer's vld_out.

Parameters:
- NO_REQ, 4, number of requesters (≥2).
- NO_CH, 10, channels per beat, same as the deserializer.
- BW_IN, 2, bits per channel per beat.
- BW_OUT, 8, bits per channel per word; must be an integer multiple of BW_IN (elaboration-time check, fatal otherwise).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_vld  in  NO_REQ  per-requester beat valid.
- req_data  in  [NO_REQ][NO_CH][BW_IN]  per-requester beat data.
- req_rdy  out  NO_REQ  per-requester beat accept; a beat transfers when vld & rdy.
- ser_vld  out  1  to deserializer vld_in.
- ser_data  out  [NO_CH][BW_IN]  to deserializer data_in.
- deser_vld  in  1  from deserializer vld_out; used only with the optional feature.
- tag_vld  out  1  word-complete pulse, coincident with deserializer vld_out.
- tag_id  out  $clog2(NO_REQ)  owner of the completed word.
- sync_err  out  1  sticky alignment error (optional feature).

Behaviour:
- Reset: one clock and sync active-high reset, as already decided. Same rst also resets the deserializer, so the beat counters are aligned by construction.
- Values held during reset:
  - state=IDLE, owner=0, beat_cnt=0, rr_ptr=0.
  - req_rdy=0, ser_vld=0, tag_vld=0, tag_id=0, sync_err=0.
- Derived constants: NO_CYC=BW_OUT/BW_IN; beat_cnt width $clog2(NO_CYC), minimum 1.
- FSM states are IDLE and BURST.
- IDLE:
  - If any req_vld is set, pick the first set bit searching from rr_ptr upward with wrap. Register it as owner, set beat_cnt=0, go to BURST.
  - Grant latency is 1 cycle; no beat is accepted in IDLE.
- BURST outputs (combinational from registered state):
  - req_rdy[owner]=1, all other req_rdy=0.
  - ser_vld=req_vld[owner].
  - ser_data=req_data[owner].
- Outside BURST, ser_data=0.
- Each accepted beat increments beat_cnt.
- Owner drops req_vld mid-word: grant is held indefinitely, ser_vld=0. Other requesters wait; there is no preemption.
- Last beat accepted (beat_cnt==NO_CYC-1):
  - rr_ptr ← owner+1 mod NO_REQ; beat_cnt ← 0.
  - Re-arbitrate in the same cycle over the current req_vld, searching from owner+1. If a winner exists, load it and stay in BURST (zero-bubble back-to-back). Otherwise go to IDLE.
  - The current owner may win again only if no other requester is valid.
- Tag: on the cycle after the last beat, tag_vld=1 for one cycle and tag_id=the completing owner, registered. This is the same cycle the deserializer raises vld_out.
- NO_CYC==1: every accepted beat is a last beat; arbitration rotates on every beat.
- Reset mid-word: partial word is discarded, tag_vld stays 0 for it, state returns to IDLE. The first word after reset is complete and correct.
- Back-to-back last beats produce consecutive tag_vld pulses with distinct tag_id.

Optional Feature:
- Macro: DESER_CHECK_EN.
- Defined:
  - sync_err is set and held when deser_vld != tag_vld in any cycle.
  - Cleared only by rst.
- Undefined:
  - sync_err is tied 0.
  - deser_vld is ignored (left unconnected internally).

Decomposition:
- Package deser_arb_pkg:
  - state enum {IDLE, BURST}.
  - Function rr_pick(vld, start), returning winner index and a found flag.
  - Function calc_no_cyc(BW_OUT, BW_IN).
- Sub-module rr_arbiter: combinational round-robin pick with a start-pointer input. It is reused by both the IDLE and last-beat arbitration paths.

Test Plan (NO_REQ=4, NO_CH=10, BW_IN=2, BW_OUT=8, NO_CYC=4, deserializer instantiated):
- Single requester: req 2 continuously valid, beats 1,2,3,0 on all channels -> ser_vld high for 4 cycles; tag_vld one cycle later with tag_id=2; deserializer data_out=0x39 on every channel.
- All four continuously valid -> owners 0,1,2,3,0, each holding 4 beats. Only the first grant has a 1-cycle bubble; the tag_id sequence is 0,1,2,3.
- Stall: owner 1 drops vld after 2 beats for 5 cycles while req 3 is valid -> req_rdy[3] stays 0 and owner stays 1. On resume 2 more beats complete the word, then the grant passes to 3 with no bubble.
- Reset mid-word: rst asserted after 2 beats of req 0 -> next cycle req_rdy=0 and tag_vld never fires for that word. A fresh 4-beat word afterwards yields the correct data_out and tag_id=0.
- DESER_CHECK_EN defined: force deser_vld high for 1 cycle with no pending tag -> sync_err=1 and it stays 1 through further normal traffic until rst. With the macro undefined, the same stimulus gives sync_err=0.
